latch_bank_arb: RTL and testbench

LATCH_BANK_ARB -- requirements
Module: latch_bank_arb

---
 rtl/latch_bank_arb.sv | 147 ++++++++++++++
 tb/tb_latch_bank_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/latch_bank_arb.sv
// latch_bank_arb: two-requester round-robin arbiter writing a 4 x 8-bit register bank.
// Each accepted request runs IDLE -> LOAD (byte write, LD strobe) -> ACK (one-cycle ACK pulse).
// Optional per-byte odd-parity storage and PERR output when LATCH_BANK_PARITY_EN is defined.
module latch_bank_arb #(
  parameter logic [31:0] CLR_VAL = 32'h00000000
) (
  input  logic        CK,
  input  logic        CR,
  input  logic        REQ_A,
  input  logic [1:0]  ADDR_A,
  input  logic [7:0]  DATA_A,
  output logic        ACK_A,
  input  logic        REQ_B,
  input  logic [1:0]  ADDR_B,
  input  logic [7:0]  DATA_B,
  output logic        ACK_B,
  output logic [31:0] Q,
  output logic [3:0]  LD,
`ifdef LATCH_BANK_PARITY_EN
  output logic        PERR,
`endif
  output logic        BUSY
);

  localparam int unsigned NBYTES = 4;
  localparam int unsigned BW     = 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_ACK = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;     // 0 = A, 1 = B
  logic        prio_b_q, prio_b_d;   // 1 = B wins the next contention
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] q_q, q_d;
  logic [3:0]  ld_q, ld_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        busy_q, busy_d;
  logic        grant_b;

`ifdef LATCH_BANK_PARITY_EN
  // Odd parity per byte: stored bit makes byte+bit contain an odd number of ones.
  function automatic logic [3:0] odd_par(input logic [31:0] v);
    logic [3:0] p;
    for (int n = 0; n < int'(NBYTES); n++) p[n] = ~^v[n*BW +: BW];
    return p;
  endfunction

  logic [3:0] par_q, par_d;
  logic       perr_q, perr_d;
`endif

  // Next-state, capture, bank-write and registered-output logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_b_d = prio_b_q;
    addr_d   = addr_q;
    data_d   = data_q;
    q_d      = q_q;
    ld_d     = 4'b0000;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    grant_b  = 1'b0;
`ifdef LATCH_BANK_PARITY_EN
    par_d    = par_q;
    perr_d   = |(par_q ^ odd_par(q_q));
`endif
    case (state_q)
      S_IDLE: begin
        if (REQ_A || REQ_B) begin
          grant_b  = REQ_B && (!REQ_A || prio_b_q);
          owner_d  = grant_b;
          addr_d   = grant_b ? ADDR_B : ADDR_A;
          data_d   = grant_b ? DATA_B : DATA_A;
          prio_b_d = !grant_b;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int n = 0; n < int'(NBYTES); n++) begin
          if (addr_q == 2'(n)) begin
            ld_d[n]          = 1'b1;
            q_d[n*BW +: BW]  = data_q;
`ifdef LATCH_BANK_PARITY_EN
            par_d[n]         = ~^data_q;
`endif
          end
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_a_d = !owner_q;
        ack_b_d = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; clear overrides every other input.
  always_ff @(posedge CK) begin
    if (CR) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      prio_b_q <= 1'b0;
      addr_q   <= 2'b00;
      data_q   <= 8'h00;
      q_q      <= CLR_VAL;
      ld_q     <= 4'b0000;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LATCH_BANK_PARITY_EN
      par_q    <= odd_par(CLR_VAL);
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_b_q <= prio_b_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      q_q      <= q_d;
      ld_q     <= ld_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
`ifdef LATCH_BANK_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign Q     = q_q;
  assign LD    = ld_q;
  assign ACK_A = ack_a_q;
  assign ACK_B = ack_b_q;
  assign BUSY  = busy_q;
`ifdef LATCH_BANK_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_latch_bank_arb.sv
// Directed self-checking bench for latch_bank_arb (parity section only with LATCH_BANK_PARITY_EN).
module tb_latch_bank_arb;

  logic        CK = 1'b0;
  logic        CR;
  logic        REQ_A, REQ_B;
  logic [1:0]  ADDR_A, ADDR_B;
  logic [7:0]  DATA_A, DATA_B;
  logic        ACK_A, ACK_B;
  logic [31:0] Q;
  logic [3:0]  LD;
  logic        BUSY;
`ifdef LATCH_BANK_PARITY_EN
  logic        PERR;
  logic [3:0]  pv;
`endif

  int checks = 0;
  int errors = 0;

  latch_bank_arb #(.CLR_VAL(32'h00000000)) dut (
    .CK(CK), .CR(CR),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .ACK_B(ACK_B),
    .Q(Q), .LD(LD),
`ifdef LATCH_BANK_PARITY_EN
    .PERR(PERR),
`endif
    .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    CR = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0;
    ADDR_A = 2'd0; ADDR_B = 2'd0; DATA_A = 8'h00; DATA_B = 8'h00;

    // Clear then idle
    tick();
    CR = 1'b0;
    check("rst_q", Q, 32'h00000000);
    check("rst_ld", 32'(LD), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_ack_a", 32'(ACK_A), 32'h0);
    check("rst_ack_b", 32'(ACK_B), 32'h0);
    tick();
    check("idle_busy", 32'(BUSY), 32'h0);

    // Single write from A: byte 2 <- 5A
    REQ_A = 1'b1; ADDR_A = 2'd2; DATA_A = 8'h5A;
    tick();
    check("w1_e0_busy", 32'(BUSY), 32'h1);
    check("w1_e0_ld", 32'(LD), 32'h0);
    tick();
    check("w1_e1_ld", 32'(LD), 32'h4);
    check("w1_e1_q", Q, 32'h005A0000);
    check("w1_e1_busy", 32'(BUSY), 32'h1);
    check("w1_e1_ack", 32'(ACK_A), 32'h0);
    tick();
    check("w1_e2_ack_a", 32'(ACK_A), 32'h1);
    check("w1_e2_ack_b", 32'(ACK_B), 32'h0);
    check("w1_e2_busy", 32'(BUSY), 32'h0);
    check("w1_e2_ld", 32'(LD), 32'h0);
    REQ_A = 1'b0;
    tick();
    check("w1_e3_ack_a", 32'(ACK_A), 32'h0);
    check("w1_e3_busy", 32'(BUSY), 32'h0);

    // Contention from clear: A first, then B
    CR = 1'b1;
    tick();
    CR = 1'b0;
    check("c_rst_q", Q, 32'h00000000);
    REQ_A = 1'b1; ADDR_A = 2'd0; DATA_A = 8'h11;
    REQ_B = 1'b1; ADDR_B = 2'd1; DATA_B = 8'h22;
    tick();
    tick();
    check("c1_ld", 32'(LD), 32'h1);
    check("c1_q", Q, 32'h00000011);
    tick();
    check("c1_ack_a", 32'(ACK_A), 32'h1);
    check("c1_ack_b", 32'(ACK_B), 32'h0);
    REQ_A = 1'b0;
    tick();
    check("c2_busy", 32'(BUSY), 32'h1);
    check("c2_wait_ack_b", 32'(ACK_B), 32'h0);
    tick();
    check("c2_ld", 32'(LD), 32'h2);
    check("c2_q", Q, 32'h00002211);
    tick();
    check("c2_ack_b", 32'(ACK_B), 32'h1);
    check("c2_ack_a", 32'(ACK_A), 32'h0);
    REQ_B = 1'b0;
    tick();

    // Next contention goes to A (B was served last)
    REQ_A = 1'b1; ADDR_A = 2'd3; DATA_A = 8'hAA;
    REQ_B = 1'b1; ADDR_B = 2'd3; DATA_B = 8'hBB;
    tick();
    tick();
    check("c3_ld", 32'(LD), 32'h8);
    check("c3_q", Q, 32'hAA002211);
    tick();
    check("c3_ack_a", 32'(ACK_A), 32'h1);
    check("c3_ack_b", 32'(ACK_B), 32'h0);
    REQ_A = 1'b0;
    tick();
    tick();
    check("c4_q", Q, 32'hBB002211);
    tick();
    check("c4_ack_b", 32'(ACK_B), 32'h1);
    REQ_B = 1'b0;
    tick();

    // Clear during LOAD aborts write of FF to byte 3
    REQ_A = 1'b1; ADDR_A = 2'd3; DATA_A = 8'hFF;
    tick();
    check("ab_busy", 32'(BUSY), 32'h1);
    CR = 1'b1;
    tick();
    CR = 1'b0; REQ_A = 1'b0;
    check("ab_q", Q, 32'h00000000);
    check("ab_ld", 32'(LD), 32'h0);
    check("ab_busy2", 32'(BUSY), 32'h0);
    tick();
    check("ab_ack_a", 32'(ACK_A), 32'h0);
    check("ab_busy3", 32'(BUSY), 32'h0);
    check("ab_q2", Q, 32'h00000000);

    // Data change after capture does not affect the write
    REQ_A = 1'b1; ADDR_A = 2'd1; DATA_A = 8'h33;
    tick();
    DATA_A = 8'hCC; ADDR_A = 2'd0;
    tick();
    check("cap_ld", 32'(LD), 32'h2);
    check("cap_q", Q, 32'h00003300);
    tick();
    check("cap_ack_a", 32'(ACK_A), 32'h1);
    REQ_A = 1'b0;
    tick();

`ifdef LATCH_BANK_PARITY_EN
    // Corrupted parity of byte 0 raises PERR; rewriting byte 0 clears it
    check("par_perr0", 32'(PERR), 32'h0);
    pv = dut.par_q;
    force dut.par_q = pv ^ 4'b0001;
    tick();
    tick();
    check("par_perr1", 32'(PERR), 32'h1);
    release dut.par_q;
    REQ_A = 1'b1; ADDR_A = 2'd0; DATA_A = 8'h07;
    tick();
    tick();
    tick();
    REQ_A = 1'b0;
    check("par_perr2", 32'(PERR), 32'h0);
    tick();
    check("par_perr3", 32'(PERR), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
